acia_poller: RTL and testbench

ACIA_POLLER -- requirements
Module: acia_poller

---
 rtl/acia_poller_if.sv | 25 ++
 rtl/acia_poller.sv | 138 +++++++++++++
 tb/tb_acia_poller.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acia_poller_if.sv
// Register-level bus between the poller and an ACIA: one address bit, read/write
// strobes, write data out and read data back one cycle after the read strobe.
interface acia_poller_if;
    logic       addr;
    logic       rd;
    logic       we;
    logic [7:0] bus_dout;
    logic [7:0] bus_din;

    modport master (
        output addr,
        output rd,
        output we,
        output bus_dout,
        input  bus_din
    );

    modport slave (
        input  addr,
        input  rd,
        input  we,
        input  bus_dout,
        output bus_din
    );
endinterface

// File: rtl/acia_poller.sv
// Polls an ACIA status register, drains received bytes into a small FIFO and
// writes one client byte per poll whenever the transmitter reports empty.
module acia_poller #(
    parameter int POLL_DIV = 16,
    parameter int RX_DEPTH = 4
) (
    input  logic          clk,
    input  logic          resetn,
    acia_poller_if.master bus,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic          overrun
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [CW-1:0] POLL_LAST = CW'(POLL_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        STAT_RD,
        STAT_WAIT,
        DATA_RD,
        DATA_WAIT,
        DATA_WR
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] poll_cnt, poll_cnt_nxt;
    logic          hold_full;
    logic [7:0]    hold_data;
    logic [AW:0]   wptr, rptr;
    logic [7:0]    mem [RX_DEPTH];
    logic          fifo_full, fifo_empty;
    logic          push, pop, drop, wr_done, tx_take;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            poll_cnt <= '0;
        end else begin
            state    <= state_nxt;
            poll_cnt <= poll_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        poll_cnt_nxt = poll_cnt;
        push         = 1'b0;
        drop         = 1'b0;
        wr_done      = 1'b0;
        case (state)
            IDLE: begin
                if (poll_cnt == POLL_LAST) begin
                    state_nxt    = STAT_RD;
                    poll_cnt_nxt = '0;
                end else begin
                    poll_cnt_nxt = poll_cnt + CNT_ONE;
                end
            end
            STAT_RD:   state_nxt = STAT_WAIT;
            // Receive side wins so the ACIA receive register is emptied before it overruns.
            STAT_WAIT: begin
                if (bus.bus_din[0])
                    state_nxt = DATA_RD;
                else if (bus.bus_din[1] && hold_full)
                    state_nxt = DATA_WR;
                else
                    state_nxt = IDLE;
            end
            DATA_RD:   state_nxt = DATA_WAIT;
            DATA_WAIT: begin
                push      = !fifo_full;
                drop      = fifo_full;
                state_nxt = STAT_RD;
            end
            DATA_WR: begin
                wr_done   = 1'b1;
                state_nxt = STAT_RD;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    assign bus.rd       = (state == STAT_RD) || (state == DATA_RD);
    assign bus.we       = (state == DATA_WR);
    assign bus.addr     = (state == DATA_RD) || (state == DATA_WR);
    assign bus.bus_dout = (state == DATA_WR) ? hold_data : 8'h00;

    assign tx_ready = !hold_full;
    assign tx_take  = tx_valid && !hold_full;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_full <= 1'b0;
            hold_data <= 8'h00;
        end else if (tx_take) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end else if (wr_done) begin
            hold_full <= 1'b0;
        end
    end

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign rx_valid   = !fifo_empty;
    assign rx_data    = mem[rptr[AW-1:0]];
    assign pop        = !fifo_empty && rx_ready;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[AW-1:0]] <= bus.bus_din;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr    <= '0;
            rptr    <= '0;
            overrun <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + PTR_ONE;
            if (pop)
                rptr <= rptr + PTR_ONE;
            if (drop)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_acia_poller.sv
// Bench for acia_poller: an ACIA responder plus a transaction-level scoreboard
// that predicts strobe timing, FIFO contents, overrun and transmitted bytes.
module tb_acia_poller;

    localparam int POLL_DIV = 6;
    localparam int RX_DEPTH = 4;
    localparam int K_NONE = 0, K_STAT = 1, K_DATA = 2, K_WR = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       overrun;

    acia_poller_if bus();

    acia_poller #(.POLL_DIV(POLL_DIV), .RX_DEPTH(RX_DEPTH)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    // ACIA side and reference model state
    logic [7:0] acia_rx[$];
    logic       tdre = 1'b0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    bit         pending = 0;
    bit         exp_ovr = 0;
    int         due = POLL_DIV;
    int         exp_kind = K_STAT;
    bit         stat_wait = 0, data_wait = 0, din_hold = 0;
    bit         st_rdrf = 0, st_tdre = 0;
    logic [7:0] rd_byte = 8'h00;
    int         n_we = 0, n_drop = 0, n_pop = 0;

    initial bus.bus_din = 8'h00;

    always @(negedge clk) begin : monitor
        int act;
        bit accept;
        bit was_full;
        bit do_pop;
        if (!resetn) begin
            tests++;
            if (bus.rd !== 1'b0 || bus.we !== 1'b0 || bus.addr !== 1'b0 || bus.bus_dout !== 8'h00 ||
                tx_ready !== 1'b1 || rx_valid !== 1'b0 || overrun !== 1'b0) begin
                failed++;
                $display("FAIL reset_hold: rd=%b we=%b addr=%b dout=%h tx_ready=%b rx_valid=%b overrun=%b, required 0 0 0 00 1 0 0",
                         bus.rd, bus.we, bus.addr, bus.bus_dout, tx_ready, rx_valid, overrun);
            end
            exp_rx.delete();
            exp_tx.delete();
            pending = 0; exp_ovr = 0; due = POLL_DIV; exp_kind = K_STAT;
            stat_wait = 0; data_wait = 0; din_hold = 0;
        end else begin
            act = bus.we ? K_WR : (bus.rd ? (bus.addr ? K_DATA : K_STAT) : K_NONE);
            accept = tx_valid && !pending;
            was_full = (exp_rx.size() >= RX_DEPTH);
            do_pop = (exp_rx.size() != 0) && rx_ready;

            tests++;
            if (due == 0) begin
                if (act !== exp_kind) begin
                    failed++;
                    $display("FAIL strobe_timing: strobe kind %0d, required %0d", act, exp_kind);
                end
                case (exp_kind)
                    K_STAT:  begin due = 1; exp_kind = K_NONE; end
                    K_DATA:  begin due = 1; exp_kind = K_STAT; end
                    default: begin due = 0; exp_kind = K_STAT; end
                endcase
            end else begin
                if (act !== K_NONE) begin
                    failed++;
                    $display("FAIL strobe_timing: strobe kind %0d, required none (%0d cycles early)", act, due);
                end
                due--;
            end

            tests++;
            if ((bus.rd && bus.we) || (act == K_NONE && bus.addr !== 1'b0) ||
                (!bus.we && bus.bus_dout !== 8'h00)) begin
                failed++;
                $display("FAIL bus_protocol: rd=%b we=%b addr=%b dout=%h, required idle bus outside strobes",
                         bus.rd, bus.we, bus.addr, bus.bus_dout);
            end

            tests++;
            if (tx_ready !== !pending) begin
                failed++;
                $display("FAIL tx_ready_model: got %b, required %b", tx_ready, !pending);
            end

            tests++;
            if (rx_valid !== (exp_rx.size() != 0)) begin
                failed++;
                $display("FAIL rx_valid_model: got %b, required %b", rx_valid, exp_rx.size() != 0);
            end else if (exp_rx.size() != 0) begin
                tests++;
                if (rx_data !== exp_rx[0]) begin
                    failed++;
                    $display("FAIL rx_data_model: got %h, required %h", rx_data, exp_rx[0]);
                end
            end

            tests++;
            if (overrun !== exp_ovr) begin
                failed++;
                $display("FAIL overrun_model: got %b, required %b", overrun, exp_ovr);
            end

            if (stat_wait) begin
                stat_wait = 0;
                if (st_rdrf) begin
                    exp_kind = K_DATA; due = 0;
                end else if (st_tdre && pending) begin
                    exp_kind = K_WR; due = 0;
                end else begin
                    exp_kind = K_STAT; due = POLL_DIV;
                end
            end

            if (do_pop) begin
                void'(exp_rx.pop_front());
                n_pop++;
            end
            if (data_wait) begin
                data_wait = 0;
                if (was_full) begin
                    exp_ovr = 1;
                    n_drop++;
                end else begin
                    exp_rx.push_back(rd_byte);
                end
            end

            if (bus.rd && !bus.addr) begin
                st_rdrf = (acia_rx.size() != 0);
                st_tdre = tdre;
                bus.bus_din = {6'($urandom), st_tdre, st_rdrf};
                stat_wait = 1;
                din_hold = 1;
            end else if (bus.rd) begin
                if (acia_rx.size() != 0) rd_byte = acia_rx.pop_front();
                else rd_byte = 8'($urandom);
                bus.bus_din = rd_byte;
                data_wait = 1;
                din_hold = 1;
            end else if (din_hold) begin
                din_hold = 0;
            end else begin
                bus.bus_din = 8'($urandom);
            end

            if (act == K_WR) begin
                n_we++;
                tests++;
                if (exp_tx.size() == 0 || bus.bus_dout !== exp_tx[0]) begin
                    failed++;
                    $display("FAIL tx_byte: wrote %h, required %h (queued %0d)", bus.bus_dout,
                             (exp_tx.size() != 0) ? exp_tx[0] : 8'h00, exp_tx.size());
                end
                if (exp_tx.size() != 0) void'(exp_tx.pop_front());
                pending = 0;
            end
            if (accept) begin
                exp_tx.push_back(tx_data);
                pending = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer_tx(input logic [7:0] b);
        tx_data = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data = 8'h00;
    endtask

    task automatic test_reset();
        int k;
        repeat (2) tick();
        tests++;
        if (bus.rd !== 1'b0 || bus.we !== 1'b0 || bus.addr !== 1'b0 || bus.bus_dout !== 8'h00) begin
            failed++;
            $display("FAIL reset_bus: rd=%b we=%b addr=%b dout=%h, required all zero", bus.rd, bus.we, bus.addr, bus.bus_dout);
        end
        tests++;
        if (tx_ready !== 1'b1 || rx_valid !== 1'b0 || overrun !== 1'b0) begin
            failed++;
            $display("FAIL reset_client: tx_ready=%b rx_valid=%b overrun=%b, required 1 0 0", tx_ready, rx_valid, overrun);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        k = 0;
        while (!bus.rd && k < 4 * POLL_DIV + 8) begin tick(); k++; end
        tests++;
        if (k !== POLL_DIV) begin
            failed++;
            $display("FAIL first_poll_delay: %0d cycles, required %0d", k, POLL_DIV);
        end
    endtask

    task automatic test_idle_poll();
        int k, w0;
        tdre = 1'b0;
        w0 = n_we;
        repeat (2) begin
            k = 0;
            do begin tick(); k++; end while (!bus.rd && k < 4 * POLL_DIV + 8);
            tests++;
            if (k !== POLL_DIV + 2 || bus.addr !== 1'b0) begin
                failed++;
                $display("FAIL idle_poll_period: %0d cycles addr=%b, required %0d addr=0", k, bus.addr, POLL_DIV + 2);
            end
        end
        tests++;
        if (n_we !== w0) begin
            failed++;
            $display("FAIL idle_no_write: %0d writes, required 0", n_we - w0);
        end
    endtask

    task automatic test_receive();
        int k;
        rx_ready = 1'b0;
        acia_rx.push_back(8'h41);
        k = 0;
        while (!(bus.rd && bus.addr) && k < 4 * POLL_DIV + 8) begin tick(); k++; end
        tests++;
        if (!(bus.rd && bus.addr)) begin
            failed++;
            $display("FAIL rx_data_read: no data strobe after %0d cycles, required one", k);
        end
        tick();
        tests++;
        if (rx_valid !== 1'b0) begin
            failed++;
            $display("FAIL rx_valid_early: got %b one cycle after read, required 0", rx_valid);
        end
        tick();
        tests++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h41) begin
            failed++;
            $display("FAIL rx_deliver: valid=%b data=%h, required 1 41", rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tests++;
        if (rx_valid !== 1'b0) begin
            failed++;
            $display("FAIL rx_pop: valid=%b after pop, required 0", rx_valid);
        end
    endtask

    task automatic test_transmit();
        int k, w0;
        tests++;
        if (tx_ready !== 1'b1) begin
            failed++;
            $display("FAIL tx_ready_idle: got %b, required 1", tx_ready);
        end
        tdre = 1'b1;
        w0 = n_we;
        offer_tx(8'h5A);
        tests++;
        if (tx_ready !== 1'b0) begin
            failed++;
            $display("FAIL tx_hold_full: tx_ready=%b after accept, required 0", tx_ready);
        end
        k = 0;
        while (!bus.we && k < 3 * (POLL_DIV + 4)) begin tick(); k++; end
        tests++;
        if (bus.we !== 1'b1 || bus.addr !== 1'b1 || bus.bus_dout !== 8'h5A) begin
            failed++;
            $display("FAIL tx_write: we=%b addr=%b dout=%h, required 1 1 5a", bus.we, bus.addr, bus.bus_dout);
        end
        tick();
        tests++;
        if (tx_ready !== 1'b1) begin
            failed++;
            $display("FAIL tx_ready_return: got %b, required 1", tx_ready);
        end
        repeat (2 * (POLL_DIV + 2)) tick();
        tests++;
        if (n_we !== w0 + 1) begin
            failed++;
            $display("FAIL tx_single_write: %0d writes, required 1", n_we - w0);
        end
        tdre = 1'b0;
    endtask

    task automatic test_priority();
        int k;
        tdre = 1'b0;
        offer_tx(8'hC3);
        repeat (POLL_DIV + 4) tick();
        acia_rx.push_back(8'h3C);
        tdre = 1'b1;
        k = 0;
        while (!(bus.rd && bus.addr) && !bus.we && k < 4 * POLL_DIV + 8) begin tick(); k++; end
        tests++;
        if (!(bus.rd && bus.addr)) begin
            failed++;
            $display("FAIL prio_read_first: rd=%b addr=%b we=%b, required data read before write", bus.rd, bus.addr, bus.we);
        end
        k = 0;
        do begin tick(); k++; end while (!bus.we && k < 4 * POLL_DIV + 8);
        tests++;
        if (k !== 4 || bus.bus_dout !== 8'hC3) begin
            failed++;
            $display("FAIL prio_write_after_repoll: write %0d cycles after read dout=%h, required 4 c3", k, bus.bus_dout);
        end
        tests++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
            failed++;
            $display("FAIL prio_rx_byte: valid=%b data=%h, required 1 3c", rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tdre = 1'b0;
    endtask

    task automatic test_overrun();
        tests++;
        if (overrun !== 1'b0 || rx_valid !== 1'b0) begin
            failed++;
            $display("FAIL overrun_precond: overrun=%b rx_valid=%b, required 0 0", overrun, rx_valid);
        end
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) acia_rx.push_back(8'(i));
        repeat (40 + 2 * POLL_DIV) tick();
        tests++;
        if (overrun !== 1'b1 || acia_rx.size() != 0) begin
            failed++;
            $display("FAIL overrun_set: overrun=%b unread=%0d, required 1 0", overrun, acia_rx.size());
        end
        for (int i = 1; i <= 4; i++) begin
            tests++;
            if (rx_valid !== 1'b1 || rx_data !== 8'(i)) begin
                failed++;
                $display("FAIL overrun_fifo_entry: valid=%b data=%h, required 1 %h", rx_valid, rx_data, 8'(i));
            end
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
        end
        repeat (2 * (POLL_DIV + 2)) tick();
        tests++;
        if (rx_valid !== 1'b0 || overrun !== 1'b1) begin
            failed++;
            $display("FAIL overrun_sticky: rx_valid=%b overrun=%b, required 0 1", rx_valid, overrun);
        end
    endtask

    task automatic test_reset_mid_write();
        int k, w0;
        tdre = 1'b0;
        offer_tx(8'h77);
        tdre = 1'b1;
        k = 0;
        while (!bus.we && k < 4 * POLL_DIV + 8) begin tick(); k++; end
        tests++;
        if (bus.we !== 1'b1) begin
            failed++;
            $display("FAIL rst_write_reached: we=%b after %0d cycles, required 1", bus.we, k);
        end
        #2 resetn = 1'b0;
        #1;
        tests++;
        if (bus.we !== 1'b0 || tx_ready !== 1'b1 || overrun !== 1'b0 || bus.bus_dout !== 8'h00) begin
            failed++;
            $display("FAIL rst_abort_write: we=%b tx_ready=%b overrun=%b dout=%h, required 0 1 0 00",
                     bus.we, tx_ready, overrun, bus.bus_dout);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        w0 = n_we;
        repeat (3 * (POLL_DIV + 2)) tick();
        tests++;
        if (n_we !== w0) begin
            failed++;
            $display("FAIL rst_no_stale_write: %0d writes, required 0", n_we - w0);
        end
        offer_tx(8'h78);
        k = 0;
        while (!bus.we && k < 4 * POLL_DIV + 8) begin tick(); k++; end
        tests++;
        if (bus.we !== 1'b1 || bus.bus_dout !== 8'h78) begin
            failed++;
            $display("FAIL rst_new_write: we=%b dout=%h, required 1 78", bus.we, bus.bus_dout);
        end
        tick();
        tdre = 1'b0;
    endtask

    task automatic test_random();
        int pushed, p0, d0, k;
        pushed = 0;
        p0 = n_pop;
        d0 = n_drop;
        for (int c = 0; c < 600; c++) begin
            rx_ready = ($urandom_range(0, 3) != 0);
            tx_valid = ($urandom_range(0, 2) == 0);
            tx_data  = 8'($urandom);
            tdre     = 1'($urandom);
            if (acia_rx.size() < 2 && $urandom_range(0, 5) == 0) begin
                acia_rx.push_back(8'($urandom));
                pushed++;
            end
            tick();
        end
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        tdre = 1'b1;
        k = 0;
        while ((acia_rx.size() != 0 || exp_tx.size() != 0 || exp_rx.size() != 0 || data_wait) &&
               k < 20 * (POLL_DIV + 6)) begin
            tick();
            k++;
        end
        tests++;
        if ((n_pop - p0) + (n_drop - d0) !== pushed || exp_tx.size() != 0) begin
            failed++;
            $display("FAIL random_drain: delivered %0d dropped %0d pending_tx %0d, required %0d bytes accounted and 0 pending",
                     n_pop - p0, n_drop - d0, exp_tx.size(), pushed);
        end
        rx_ready = 1'b0;
        tdre = 1'b0;
    endtask

    initial begin
        #2 resetn = 1'b0;
        test_reset();
        test_idle_poll();
        test_receive();
        test_transmit();
        test_priority();
        test_overrun();
        test_reset_mid_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
